mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Byte-serial memory controller: the responder side of the MEM stage and IF stage word-level load/store/fetch requests.
- Accepts one word-level request at a time from the data port (MEM stage) or the instruction port (IF stage).
- Serialises each request into 1/2/4 byte accesses on the 8-bit RAM bus, assembles read bytes little-endian, and returns a one-cycle done pulse.
- Sits between the pipeline and the byte-wide RAM/HCI bus.

Parameters:
- ADDR_WIDTH, 32, width of all address buses (MemAddrBus).

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- d_req  input  1  data request, level; held by requester until d_done
- d_we  input  1  1 = store, 0 = load
- d_sel  input  2  MemSelBus: 01 byte, 10 half, 11 word, 00 NOP
- d_addr  input  ADDR_WIDTH  data byte address
- d_wdata  input  32  store data; byte k = d_wdata[8k+7:8k]
- d_rdata  output  32  load result, zero-extended (sign extension is done in the MEM stage)
- d_done  output  1  one-cycle completion pulse
- i_req  input  1  fetch request, level; always a 4-byte read
- i_addr  input  ADDR_WIDTH  fetch address
- i_rdata  output  32  fetched instruction
- i_done  output  1  one-cycle completion pulse
- ram_addr  output  ADDR_WIDTH  RAM byte address
- ram_wr  output  1  RAM write strobe
- ram_wdata  output  8  RAM write byte
- ram_rdata  input  8  RAM read byte; valid in cycle t+1 for the ram_addr driven in cycle t

Behaviour:
- Reset: all outputs are 0. State is IDLE and the byte counter is 0.
- Reset mid-operation aborts with no done pulse and no further RAM writes; outputs return to 0 on the next cycle.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - If d_req, latch d_we, d_sel, d_addr, d_wdata and set port = D.
  - Else if i_req, latch i_addr, set sel = word, we = 0, port = I.
  - Data has priority when both requests are high. N = 1/2/4 from sel.
  - d_sel = 00 goes straight to DONE: no RAM access, d_rdata = 0.
- ISSUE, cnt 0..N-1:
  - ram_addr = A + cnt, computed mod 2^ADDR_WIDTH so addresses wrap.
  - Writes: ram_wr = 1 and ram_wdata = byte cnt.
  - Reads: the byte present on ram_rdata is captured into slot cnt-1 when cnt ≥ 1.
  - After cnt = N-1: writes go to DONE; reads go to DRAIN.
- DRAIN (reads only): capture the final byte into slot N-1, then go to DONE.
- DONE:
  - Assert d_done or i_done (per latched port) for exactly one cycle, with d_rdata/i_rdata valid in the same cycle.
  - Unused upper bytes are 0.
  - Next state is always IDLE. The done-port request is ignored in this cycle, so the requester has one cycle to drop req.
- Idle bus: whenever not in ISSUE, ram_addr = 0, ram_wr = 0, ram_wdata = 0. A zero address stops the HCI.
- Latency, measured from the cycle req is first seen in IDLE as cycle 0:
  - Reads: done in cycle N+2 (byte 3, half 4, word 6).
  - Writes: done in cycle N+1 (byte 2, half 3, word 5).
  - NOP: done in cycle 1.
- Outputs: d_rdata/i_rdata hold their last value until the next completion on the same port.
- Input stability: request inputs that change while busy are ignored; the latched copy is used.
- Back-to-back requests: the earliest acceptance of the next request is the cycle after DONE.

Decomposition:
- Shared defines (defines.v):
  - MEM_NOP/MEM_BYTE/MEM_HALF/MEM_WORD
  - MemAddrBus, MemDataBus, MemSelBus
  - new state encodings MCTRL_IDLE/ISSUE/DRAIN/DONE
- Sub-module: mem_arbiter, a combinational priority select with the port-latch enable. It is optional, and a single module is acceptable.

Test Plan:
- Word load: RAM[0x100..0x103] = 11,22,33,44; d_req with d_sel = 11, d_addr = 0x100 → ram_addr 0x100..0x103 in cycles 1-4; d_done in cycle 6 with d_rdata = 0x44332211.
- Half store: d_we = 1, d_sel = 10, d_addr = 0x200, d_wdata = 0xAABBCCDD → ram_wr in cycles 1-2 writing DD@0x200 and CC@0x201; d_done in cycle 3; RAM[0x202] unchanged.
- Byte load of 0x80 at 0x10 → d_rdata = 0x00000080 with d_done in cycle 3.
- d_req and i_req raised in the same cycle → data completes first; i_req accepted the cycle after d_done; i_done 6 cycles after that acceptance.
- Wrap-around: word load at 0xFFFFFFFE → ram_addr sequence FFFFFFFE, FFFFFFFF, 0, 1.
- rst asserted in cycle 2 of a word store → no further ram_wr; no d_done; ram_addr = 0 next cycle; a subsequent byte load completes normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and encodings for the byte-serial memory controller.
// Access sizes, FSM states and the port tag used by the arbiter and top.
package mem_ctrl_pkg;

  typedef logic [7:0]  mem_byte_t;
  typedef logic [31:0] mem_data_t;
  typedef logic [1:0]  mem_sel_t;

  localparam mem_sel_t MEM_NOP  = 2'b00;
  localparam mem_sel_t MEM_BYTE = 2'b01;
  localparam mem_sel_t MEM_HALF = 2'b10;
  localparam mem_sel_t MEM_WORD = 2'b11;

  typedef enum logic [1:0] {
    McIdle,
    McIssue,
    McDrain,
    McDone
  } mctrl_state_e;

  typedef enum logic {
    PortD,
    PortI
  } mem_port_e;

  // Index of the last byte of an access (N-1); NOP never reaches ISSUE.
  function automatic logic [1:0] sel_last(input mem_sel_t sel);
    logic [1:0] last;
    unique case (sel)
      MEM_HALF: last = 2'd1;
      MEM_WORD: last = 2'd3;
      default:  last = 2'd0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/mem_ctrl_arbiter.sv
// Fixed-priority select between the data and instruction request ports.
// Data wins; accept is only raised while the controller is idle.
module mem_ctrl_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  idle,
  input  logic                  d_req,
  input  logic                  d_we,
  input  mem_sel_t              d_sel,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  mem_data_t             d_wdata,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  accept,
  output mem_port_e             port,
  output logic                  we,
  output mem_sel_t              sel,
  output logic [ADDR_WIDTH-1:0] addr,
  output mem_data_t             wdata
);

  always_comb begin
    accept = 1'b0;
    port   = PortD;
    we     = 1'b0;
    sel    = MEM_NOP;
    addr   = '0;
    wdata  = '0;
    if (idle && d_req) begin
      accept = 1'b1;
      port   = PortD;
      we     = d_we;
      sel    = d_sel;
      addr   = d_addr;
      wdata  = d_wdata;
    end else if (idle && i_req) begin
      accept = 1'b1;
      port   = PortI;
      sel    = MEM_WORD;
      addr   = i_addr;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: turns word-level load/store/fetch requests
// into 1/2/4 byte accesses on an 8-bit RAM bus, assembling reads little-endian.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [1:0]            d_sel,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  output logic [31:0]           d_rdata,
  output logic                  d_done,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [31:0]           i_rdata,
  output logic                  i_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr,
  output logic [7:0]            ram_wdata,
  input  logic [7:0]            ram_rdata
);

  mctrl_state_e          state_q;
  mem_port_e             port_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  mem_data_t             wdata_q;
  logic [1:0]            last_q;
  logic [1:0]            cnt_q;
  mem_data_t             rbuf_q;

  logic                  arb_accept;
  mem_port_e             arb_port;
  logic                  arb_we;
  mem_sel_t              arb_sel;
  logic [ADDR_WIDTH-1:0] arb_addr;
  mem_data_t             arb_wdata;

  logic [1:0]            nxt_cnt;
  logic [1:0]            prev_cnt;
  mem_data_t             drain_word;

  mem_ctrl_arbiter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_arbiter (
    .idle   (state_q == McIdle),
    .d_req  (d_req),
    .d_we   (d_we),
    .d_sel  (d_sel),
    .d_addr (d_addr),
    .d_wdata(d_wdata),
    .i_req  (i_req),
    .i_addr (i_addr),
    .accept (arb_accept),
    .port   (arb_port),
    .we     (arb_we),
    .sel    (arb_sel),
    .addr   (arb_addr),
    .wdata  (arb_wdata)
  );

  always_comb begin
    nxt_cnt  = cnt_q + 2'd1;
    prev_cnt = cnt_q - 2'd1;
    // Final read byte arrives one cycle after the last address was issued.
    drain_word = rbuf_q;
    drain_word[{last_q, 3'b000} +: 8] = ram_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= McIdle;
      port_q    <= PortD;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
      rbuf_q    <= '0;
      d_rdata   <= '0;
      d_done    <= 1'b0;
      i_rdata   <= '0;
      i_done    <= 1'b0;
      ram_addr  <= '0;
      ram_wr    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      d_done <= 1'b0;
      i_done <= 1'b0;
      unique case (state_q)
        McIdle: begin
          if (arb_accept) begin
            port_q  <= arb_port;
            we_q    <= arb_we;
            addr_q  <= arb_addr;
            wdata_q <= arb_wdata;
            last_q  <= sel_last(arb_sel);
            cnt_q   <= '0;
            rbuf_q  <= '0;
            if (arb_sel == MEM_NOP) begin
              // Only the data port can carry a NOP.
              state_q <= McDone;
              d_done  <= 1'b1;
              d_rdata <= '0;
            end else begin
              state_q   <= McIssue;
              ram_addr  <= arb_addr;
              ram_wr    <= arb_we;
              ram_wdata <= arb_we ? arb_wdata[7:0] : 8'h00;
            end
          end
        end
        McIssue: begin
          if (!we_q && cnt_q != 2'd0) begin
            rbuf_q[{prev_cnt, 3'b000} +: 8] <= ram_rdata;
          end
          if (cnt_q == last_q) begin
            ram_addr  <= '0;
            ram_wr    <= 1'b0;
            ram_wdata <= '0;
            if (we_q) begin
              state_q <= McDone;
              if (port_q == PortD) d_done <= 1'b1;
              else                 i_done <= 1'b1;
            end else begin
              state_q <= McDrain;
            end
          end else begin
            cnt_q     <= nxt_cnt;
            ram_addr  <= addr_q + ADDR_WIDTH'(nxt_cnt);
            ram_wr    <= we_q;
            ram_wdata <= we_q ? wdata_q[{nxt_cnt, 3'b000} +: 8] : 8'h00;
          end
        end
        McDrain: begin
          state_q <= McDone;
          rbuf_q  <= drain_word;
          if (port_q == PortD) begin
            d_done  <= 1'b1;
            d_rdata <= drain_word;
          end else begin
            i_done  <= 1'b1;
            i_rdata <= drain_word;
          end
        end
        McDone: begin
          state_q <= McIdle;
        end
        default: begin
          state_q <= McIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a 4 KiB byte RAM model
// (one-cycle read latency) aliased on the low 12 address bits.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [1:0]  d_sel = 2'b00;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_done;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mem [0:4095];
  logic        pl_we = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  logic [31:0] a_log  [16];
  logic        w_log  [16];
  logic [7:0]  wd_log [16];

  always #5 clk = ~clk;

  mem_ctrl #(
    .ADDR_WIDTH(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_sel    (d_sel),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_done   (i_done),
    .ram_addr (ram_addr),
    .ram_wr   (ram_wr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr[11:0]];
    if (pl_we)       mem[pl_addr] <= pl_data;
    else if (ram_wr) mem[ram_addr[11:0]] <= ram_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] v);
    pl_we = 1'b1;
    pl_addr = a;
    pl_data = v;
    @(posedge clk);
    #1;
    pl_we = 1'b0;
  endtask

  // Entered 1 time unit after a rising edge; that cycle is cycle 0.
  task automatic run_d(input logic we, input logic [1:0] sel, input logic [31:0] addr,
                       input logic [31:0] wdata, output int done_cyc,
                       output logic [31:0] rdata);
    d_req = 1'b1;
    d_we = we;
    d_sel = sel;
    d_addr = addr;
    d_wdata = wdata;
    done_cyc = -1;
    rdata = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      a_log[c] = ram_addr;
      w_log[c] = ram_wr;
      wd_log[c] = ram_wdata;
      if (d_done) begin
        done_cyc = c;
        rdata = d_rdata;
        d_req = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done_cyc >= 0) break;
    end
    d_req = 1'b0;
  endtask

  initial begin
    int          dc;
    int          ic;
    logic [31:0] rd;
    logic [31:0] ird;
    logic [31:0] drd_at_i;
    int          bad;

    @(posedge clk);
    #1;
    poke(12'h100, 8'h11); poke(12'h101, 8'h22); poke(12'h102, 8'h33); poke(12'h103, 8'h44);
    poke(12'h202, 8'h5A); poke(12'h010, 8'h80);
    poke(12'h300, 8'h13); poke(12'h301, 8'h05); poke(12'h302, 8'h00); poke(12'h303, 8'h00);
    poke(12'hFFE, 8'hA1); poke(12'hFFF, 8'hB2); poke(12'h000, 8'hC3); poke(12'h001, 8'hD4);
    for (int k = 0; k < 4; k++) poke(12'h400 + 12'(k), 8'hEE);

    @(negedge clk);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_wr", {31'h0, ram_wr}, 32'h0);
    check("rst_done", {30'h0, d_done, i_done}, 32'h0);
    check("rst_rdata", d_rdata | i_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Word load
    run_d(1'b0, 2'b11, 32'h100, 32'h0, dc, rd);
    check("wl_addr_c0", a_log[0], 32'h0);
    for (int k = 1; k <= 4; k++) check($sformatf("wl_addr_c%0d", k), a_log[k], 32'h100 + 32'(k - 1));
    check("wl_addr_c5", a_log[5], 32'h0);
    check("wl_done_cyc", 32'(dc), 32'd6);
    check("wl_rdata", rd, 32'h44332211);

    // Half store
    run_d(1'b1, 2'b10, 32'h200, 32'hAABBCCDD, dc, rd);
    check("hs_wr_c1", {a_log[1][23:0], wd_log[1]}, {24'h000200, 8'hDD});
    check("hs_wr_c2", {a_log[2][23:0], wd_log[2]}, {24'h000201, 8'hCC});
    check("hs_wr_flags", {29'h0, w_log[0], w_log[1], w_log[2]}, 32'b011);
    check("hs_done_cyc", 32'(dc), 32'd3);
    check("hs_wr_c3", {31'h0, w_log[3]}, 32'h0);
    check("hs_mem", {8'h0, mem[12'h200], mem[12'h201], mem[12'h202]}, 32'h00DDCC5A);

    // Byte load
    run_d(1'b0, 2'b01, 32'h10, 32'h0, dc, rd);
    check("bl_done_cyc", 32'(dc), 32'd3);
    check("bl_rdata", rd, 32'h00000080);

    // NOP
    run_d(1'b0, 2'b00, 32'h100, 32'h0, dc, rd);
    check("nop_done_cyc", 32'(dc), 32'd1);
    check("nop_rdata", rd, 32'h0);
    check("nop_bus", {30'h0, w_log[0], w_log[1]} | a_log[0] | a_log[1], 32'h0);

    // Simultaneous data and fetch requests
    d_req = 1'b1; d_we = 1'b0; d_sel = 2'b11; d_addr = 32'h100;
    i_req = 1'b1; i_addr = 32'h300;
    dc = -1;
    ic = -1;
    ird = '0;
    drd_at_i = '0;
    rd = '0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (d_done && dc < 0) begin dc = c; rd = d_rdata; d_req = 1'b0; end
      if (i_done && ic < 0) begin ic = c; ird = i_rdata; drd_at_i = d_rdata; i_req = 1'b0; end
      @(posedge clk);
      #1;
      if (ic >= 0) break;
    end
    d_req = 1'b0;
    i_req = 1'b0;
    check("dual_d_done_cyc", 32'(dc), 32'd6);
    check("dual_d_rdata", rd, 32'h44332211);
    check("dual_i_done_cyc", 32'(ic), 32'd13);
    check("dual_i_rdata", ird, 32'h00000513);
    check("dual_d_rdata_hold", drd_at_i, 32'h44332211);

    // Address wrap-around
    run_d(1'b0, 2'b11, 32'hFFFFFFFE, 32'h0, dc, rd);
    check("wrap_a1", a_log[1], 32'hFFFFFFFE);
    check("wrap_a2", a_log[2], 32'hFFFFFFFF);
    check("wrap_a3", a_log[3], 32'h00000000);
    check("wrap_a4", a_log[4], 32'h00000001);
    check("wrap_rdata", rd, 32'hD4C3B2A1);

    // Reset in cycle 2 of a word store
    d_req = 1'b1; d_we = 1'b1; d_sel = 2'b11; d_addr = 32'h400; d_wdata = 32'h01020304;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rs_c1_wr", {ram_wr, ram_addr[30:0]}, {1'b1, 31'h400});
    @(posedge clk);
    #1;
    rst = 1'b1;
    d_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rs_c3_addr", ram_addr, 32'h0);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      if (ram_wr || d_done || i_done) bad++;
    end
    check("rs_quiet", 32'(bad), 32'd0);
    check("rs_mem", {16'h0, mem[12'h402], mem[12'h403]}, 32'h0000EEEE);
    @(posedge clk);
    #1;
    run_d(1'b0, 2'b01, 32'h10, 32'h0, dc, rd);
    check("rs_bl_done_cyc", 32'(dc), 32'd3);
    check("rs_bl_rdata", rd, 32'h00000080);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
